// File: rtl/onn_settle_monitor.sv
// Settle monitor for the 3x5 neuron bank: samples nout once per oscillation period, declares
// convergence or timeout, then shifts the settled pattern out MSB-first over valid/ready.
module onn_settle_monitor #(
    parameter int unsigned N_NEURON       = 15,
    parameter int unsigned STABLE_PERIODS = 4,
    parameter int unsigned MAX_PERIODS    = 200,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                sclk,
    input  logic                re,
    input  logic                start,
    input  logic [N_NEURON-1:0] nout,
    input  logic                phi_to_no,
    input  logic                result_ready,
    output logic                busy,
    output logic                converged,
    output logic                timeout,
    output logic [N_NEURON-1:0] pattern,
    output logic [CNT_W-1:0]    period_count,
    output logic                sdo,
    output logic                sdo_valid,
    output logic                sdo_last
);

    localparam int unsigned MATCH_W = $clog2(STABLE_PERIODS + 1);
    localparam int unsigned IDX_W   = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WAIT1 = 3'd1;
    localparam logic [2:0] TRACK = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    logic [2:0]          state_q, state_d;
    logic                phi_q;
    logic [N_NEURON-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0]    count_q, count_d, count_inc;
    logic [MATCH_W-1:0]  match_q, match_d, match_inc;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                converged_q, converged_d;
    logic                timeout_q, timeout_d;
    logic                period_event;
    logic                same;

    // A strobe held high for several cycles yields a single period event.
    assign period_event = phi_to_no & ~phi_q;
    assign same         = (nout == pattern_q);
    assign count_inc    = count_q + 1'b1;
    assign match_inc    = match_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        count_d     = count_q;
        match_d     = match_q;
        idx_d       = idx_q;
        converged_d = converged_q;
        timeout_d   = timeout_q;

        // start aborts or re-arms from any state and masks a coincident event.
        if (start) begin
            count_d     = '0;
            match_d     = '0;
            converged_d = 1'b0;
            timeout_d   = 1'b0;
            state_d     = WAIT1;
        end else begin
            case (state_q)
                WAIT1: begin
                    if (period_event) begin
                        pattern_d = nout;
                        count_d   = CNT_W'(1);
                        match_d   = '0;
                        state_d   = TRACK;
                    end
                end
                TRACK: begin
                    if (period_event) begin
                        pattern_d = nout;
                        count_d   = count_inc;
                        match_d   = same ? match_inc : '0;
                        if (same && (match_inc == MATCH_W'(STABLE_PERIODS))) begin
                            converged_d = 1'b1;
                            idx_d       = IDX_W'(N_NEURON - 1);
                            state_d     = SHIFT;
                        end else if (count_inc == CNT_W'(MAX_PERIODS)) begin
                            timeout_d = 1'b1;
                            idx_d     = IDX_W'(N_NEURON - 1);
                            state_d   = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (result_ready) begin
                        if (idx_q == '0) begin
                            state_d = HOLD;
                        end else begin
                            idx_d = idx_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (re) begin
            state_q     <= IDLE;
            phi_q       <= 1'b0;
            pattern_q   <= '0;
            count_q     <= '0;
            match_q     <= '0;
            idx_q       <= '0;
            converged_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phi_q       <= phi_to_no;
            pattern_q   <= pattern_d;
            count_q     <= count_d;
            match_q     <= match_d;
            idx_q       <= idx_d;
            converged_q <= converged_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        busy         = (state_q != IDLE) && (state_q != HOLD);
        converged    = converged_q;
        timeout      = timeout_q;
        pattern      = pattern_q;
        period_count = count_q;
        sdo_valid    = (state_q == SHIFT);
        sdo          = sdo_valid & pattern_q[idx_q];
        sdo_last     = sdo_valid & (idx_q == '0);
    end

endmodule

// File: tb/tb_onn_settle_monitor.sv
// Scoreboard bench for onn_settle_monitor: stimulus pushes expected results and serial bits,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_onn_settle_monitor;

    logic        sclk = 1'b0;
    logic        re = 1'b1;
    logic        start = 1'b0;
    logic [14:0] nout = '0;
    logic        phi_to_no = 1'b0;
    logic        result_ready = 1'b1;
    logic        busy, converged, timeout, sdo, sdo_valid, sdo_last;
    logic [14:0] pattern;
    logic [7:0]  period_count;

    onn_settle_monitor #(
        .N_NEURON      (15),
        .STABLE_PERIODS(4),
        .MAX_PERIODS   (200),
        .CNT_W         (8)
    ) dut (
        .sclk        (sclk),
        .re          (re),
        .start       (start),
        .nout        (nout),
        .phi_to_no   (phi_to_no),
        .result_ready(result_ready),
        .busy        (busy),
        .converged   (converged),
        .timeout     (timeout),
        .pattern     (pattern),
        .period_count(period_count),
        .sdo         (sdo),
        .sdo_valid   (sdo_valid),
        .sdo_last    (sdo_last)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic        conv;
        logic        to;
        logic [7:0]  cnt;
        logic [14:0] pat;
    } res_t;

    res_t       res_q[$];
    logic [1:0] bit_q[$];  // {last, data}
    int         tests = 0;
    int         failed = 0;
    bit         bp_mode = 0;
    int         cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
        cyc++;
        if (bp_mode) result_ready = (cyc % 3 == 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic period(input logic [14:0] val, input int width);
        nout      = val;
        phi_to_no = 1'b1;
        repeat (width) tick();
        phi_to_no = 1'b0;
        tick();
        tick();
    endtask

    task automatic expect_run(input logic conv, input logic to, input logic [7:0] cnt,
                              input logic [14:0] pat, input int nbits);
        res_t r;
        r.conv = conv;
        r.to   = to;
        r.cnt  = cnt;
        r.pat  = pat;
        res_q.push_back(r);
        for (int i = 14; i > 14 - nbits; i--) bit_q.push_back({i == 0, pat[i]});
    endtask

    task automatic wait_hold(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({name, "_hold_busy"}, busy, 0);
        check({name, "_hold_valid"}, sdo_valid, 0);
    endtask

    // Monitor: result fields on SHIFT entry, stability during stalls, bits on each transfer.
    initial begin
        logic prev_valid = 0, prev_stall = 0, prev_sdo = 0, prev_last = 0;
        res_t r;
        logic [1:0] b;
        forever begin
            @(negedge sclk);
            if (sdo_valid && !prev_valid) begin
                if (res_q.size() == 0) begin
                    check("unexpected_shift", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    check("converged", converged, r.conv);
                    check("timeout", timeout, r.to);
                    check("period_count", period_count, r.cnt);
                    check("pattern", pattern, r.pat);
                end
            end
            if (sdo_valid && prev_stall) begin
                check("stall_sdo", sdo, prev_sdo);
                check("stall_last", sdo_last, prev_last);
            end
            if (sdo_valid && result_ready) begin
                if (bit_q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    b = bit_q.pop_front();
                    check("sdo", sdo, b[0]);
                    check("sdo_last", sdo_last, b[1]);
                end
            end
            prev_valid = sdo_valid;
            prev_stall = sdo_valid && !result_ready;
            prev_sdo   = sdo;
            prev_last  = sdo_last;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        re = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_flags", {converged, timeout}, 0);
        check("rst_pattern", pattern, 0);
        check("rst_count", period_count, 0);
        check("rst_serial", {sdo, sdo_valid, sdo_last}, 0);

        // Converge on 2A5
        pulse_start();
        check("conv_busy", busy, 1);
        expect_run(1, 0, 5, 15'h02A5, 15);
        repeat (4) period(15'h02A5, 1);
        check("conv_not_early", converged, 0);
        check("conv_cnt4", period_count, 4);
        period(15'h02A5, 1);
        wait_hold(40, "conv");
        check("conv_held", {converged, timeout}, 2'b10);
        check("conv_held_cnt", period_count, 5);

        // Timeout with alternating pattern
        pulse_start();
        check("to_cleared", {converged, timeout, period_count}, 0);
        expect_run(0, 1, 200, 15'h0000, 15);
        for (int k = 1; k <= 200; k++) period((k % 2) ? 15'h7FFF : 15'h0000, 1);
        wait_hold(40, "to");
        check("to_held", {converged, timeout}, 2'b01);

        // Backpressure during SHIFT
        pulse_start();
        expect_run(1, 0, 5, 15'h4C3B, 15);
        repeat (5) period(15'h4C3B, 1);
        bp_mode = 1;
        wait_hold(100, "bp");
        bp_mode = 0;
        result_ready = 1'b1;

        // Wide strobe: one sample per period
        pulse_start();
        expect_run(1, 0, 5, 15'h1234, 15);
        repeat (4) period(15'h1234, 6);
        check("wide_cnt4", period_count, 4);
        check("wide_not_early", converged, 0);
        period(15'h1234, 6);
        wait_hold(40, "wide");

        // Pattern change resets the match counter
        pulse_start();
        expect_run(1, 0, 9, 15'h5555, 15);
        repeat (3) period(15'h5555, 1);
        period(15'h2AAA, 1);
        check("chg_cnt4", period_count, 4);
        repeat (5) period(15'h5555, 1);
        wait_hold(40, "chg");

        // start mid-TRACK aborts the run
        pulse_start();
        repeat (3) period(15'h0F0F, 1);
        pulse_start();
        check("abort_cnt", period_count, 0);
        check("abort_busy", busy, 1);
        period(15'h0F0F, 1);
        check("abort_reentry_cnt", period_count, 1);
        expect_run(1, 0, 5, 15'h0F0F, 15);
        repeat (4) period(15'h0F0F, 1);
        wait_hold(40, "abort");

        // re mid-SHIFT at idx 7
        pulse_start();
        expect_run(1, 0, 5, 15'h7123, 7);
        repeat (4) period(15'h7123, 1);
        nout      = 15'h7123;
        phi_to_no = 1'b1;
        tick();
        repeat (7) tick();
        re           = 1'b1;
        result_ready = 1'b0;
        phi_to_no    = 1'b0;
        tick();
        check("re_busy", busy, 0);
        check("re_flags", {converged, timeout}, 0);
        check("re_pattern", pattern, 0);
        check("re_count", period_count, 0);
        check("re_serial", {sdo, sdo_valid, sdo_last}, 0);
        re           = 1'b0;
        result_ready = 1'b1;
        tick();
        tick();

        check("res_q_empty", res_q.size(), 0);
        check("bit_q_empty", bit_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
